// File: rtl/register_writer.sv
// Write-back owner of the eip/ebp/esp registers. Commands arrive over a
// valid/ready handshake and are applied by a small IDLE/EXEC/EXEC2 FSM.
module register_writer #(
    parameter logic [31:0] EIP_RESET  = 32'h0000_0000,
    parameter logic [31:0] EBP_RESET  = 32'h0000_0000,
    parameter logic [31:0] ESP_RESET  = 32'h0000_FFFC,
    parameter int unsigned STACK_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic        eip_adv,
    input  logic [3:0]  eip_len,
    output logic        wr_done,
    output logic        wr_err,
    output logic [31:0] eip,
    output logic [31:0] ebp,
    output logic [31:0] esp
);

    // state | meaning
    // IDLE  | waiting for a command, wr_ready high
    // EXEC  | apply captured command (first LEAVE step: esp <= ebp)
    // EXEC2 | second LEAVE step: ebp <= data
    typedef enum logic [1:0] {IDLE, EXEC, EXEC2} state_t;

    localparam logic [31:0] STEP = 32'(STACK_STEP);

    state_t      state, state_nxt;
    logic [3:0]  sel_q, sel_nxt;
    logic [31:0] data_q, data_nxt;
    logic [31:0] eip_nxt, ebp_nxt, esp_nxt;
    logic        done_nxt, err_nxt;

    assign wr_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        data_nxt  = data_q;
        eip_nxt   = eip_adv ? eip + {28'd0, eip_len} : eip;
        ebp_nxt   = ebp;
        esp_nxt   = esp;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_valid) begin
                    sel_nxt   = wr_sel;
                    data_nxt  = wr_data;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                case (sel_q)
                    4'h1: esp_nxt = esp - STEP;
                    4'h2: esp_nxt = esp + STEP;
                    4'h3: ebp_nxt = data_q;
                    4'h4: esp_nxt = data_q;
                    4'h5: ebp_nxt = esp;
                    4'h6: begin
                        esp_nxt   = ebp;
                        state_nxt = EXEC2;
                        done_nxt  = 1'b0;
                    end
                    // JUMP overrides any eip advance on the same edge
                    4'h7: eip_nxt = data_q;
                    default: err_nxt = sel_q[3];
                endcase
            end
            EXEC2: begin
                ebp_nxt   = data_q;
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_q   <= 4'h0;
            data_q  <= 32'h0;
            eip     <= EIP_RESET;
            ebp     <= EBP_RESET;
            esp     <= ESP_RESET;
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel_q   <= sel_nxt;
            data_q  <= data_nxt;
            eip     <= eip_nxt;
            ebp     <= ebp_nxt;
            esp     <= esp_nxt;
            wr_done <= done_nxt;
            wr_err  <= err_nxt;
        end
    end

endmodule
